// File: rtl/mp_add_pkg.sv
// Shared constants and FSM encoding for the multi-precision word-serial adder.
package mp_add_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_WORDS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mp_add_seq_if.sv
// Operand read port, result write port and control/status of mp_add_seq.
interface mp_add_seq_if
  import mp_add_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = $clog2(DEF_WORDS)
);

  logic          iStart;
  logic          iSub;
  logic          iAbort;
  logic          oRdEn;
  logic [AW-1:0] oRdAddr;
  logic [W-1:0]  iA;
  logic [W-1:0]  iB;
  logic          oWrEn;
  logic [AW-1:0] oWrAddr;
  logic [W-1:0]  oWrData;
  logic          oBusy;
  logic          oDone;
  logic          oCarry;

  modport slave (
    input  iStart, iSub, iAbort, iA, iB,
    output oRdEn, oRdAddr, oWrEn, oWrAddr, oWrData, oBusy, oDone, oCarry
  );

  modport master (
    output iStart, iSub, iAbort, iA, iB,
    input  oRdEn, oRdAddr, oWrEn, oWrAddr, oWrData, oBusy, oDone, oCarry
  );

endinterface

// File: rtl/mp_add_seq_word_adc.sv
// One W-bit slice of the ripple: a + (inv_b ? ~b : b) + cin.
module word_adc #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         inv_b,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_eff;

  assign b_eff       = inv_b ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// Word-serial multi-precision add/subtract: streams WORDS operand words LSW
// first, writes one result word per cycle, carry chained through a flop.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int WORDS = DEF_WORDS,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic        iClk,
  input  logic        iRst_n,
  mp_add_seq_if.slave bus
);

  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  state_e        state_q, state_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic          rd_vld_q, rd_vld_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;

  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]  wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cout_q, cout_d;

  logic [W-1:0]  sum_w;
  logic          sum_c;

  word_adc #(.W(W)) u_adc (
    .a     (bus.iA),
    .b     (bus.iB),
    .cin   (carry_q),
    .inv_b (sub_q),
    .sum   (sum_w),
    .cout  (sum_c)
  );

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    rd_vld_d  = rd_en_q;
    rd_idx_d  = rd_addr_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cout_d    = cout_q;

    // Operand data lags its read strobe by one cycle, so rd_vld/rd_idx
    // mark which word is on iA/iB right now.
    if ((state_q == RUN || state_q == DRAIN) && rd_vld_q) begin
      wr_en_d   = 1'b1;
      wr_addr_d = rd_idx_q;
      wr_data_d = sum_w;
      carry_d   = sum_c;
    end

    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          state_d   = RUN;
          sub_d     = bus.iSub;
          carry_d   = bus.iSub;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      RUN: begin
        if (rd_addr_q == LAST) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
        cout_d  = sum_c;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over the final write/done of the same cycle.
    if (bus.iAbort && (state_q == RUN || state_q == DRAIN)) begin
      state_d   = IDLE;
      carry_d   = 1'b0;
      rd_vld_d  = 1'b0;
      rd_en_d   = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      cout_d    = cout_q;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      carry_q   <= carry_d;
      rd_vld_q  <= rd_vld_d;
      rd_idx_q  <= rd_idx_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cout_q    <= cout_d;
    end
  end

  assign bus.oRdEn   = rd_en_q;
  assign bus.oRdAddr = rd_addr_q;
  assign bus.oWrEn   = wr_en_q;
  assign bus.oWrAddr = wr_addr_q;
  assign bus.oWrData = wr_data_q;
  assign bus.oBusy   = busy_q;
  assign bus.oDone   = done_q;
  assign bus.oCarry  = cout_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed + random bench for mp_add_seq against a whole-vector arithmetic model.
module tb_mp_add_seq;
  import mp_add_pkg::*;

  localparam int W     = DEF_W;
  localparam int WORDS = DEF_WORDS;
  localparam int AW    = $clog2(WORDS);
  localparam int N     = W * WORDS;

  typedef logic [N:0]   wide_t;
  typedef logic [N-1:0] vec_t;

  logic iClk = 1'b0;
  logic iRst_n;
  always #5 iClk = ~iClk;

  mp_add_seq_if #(.W(W), .AW(AW)) bus ();

  mp_add_seq #(.W(W), .WORDS(WORDS), .AW(AW)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Operand memory: registered read, data one cycle after the strobe.
  logic [W-1:0] mem_a [WORDS];
  logic [W-1:0] mem_b [WORDS];
  always @(posedge iClk) begin
    if (bus.oRdEn) begin
      bus.iA <= mem_a[bus.oRdAddr];
      bus.iB <= mem_b[bus.oRdAddr];
    end else begin
      bus.iA <= $urandom;
      bus.iB <= $urandom;
    end
  end

  // Result capture
  vec_t res;
  int   wr_cnt, wr_order_err, cyc, first_wr, last_wr;
  always @(negedge iClk) begin
    cyc++;
    if (bus.oWrEn) begin
      if (bus.oWrAddr != AW'(wr_cnt)) wr_order_err++;
      res[bus.oWrAddr*W +: W] = bus.oWrData;
      if (wr_cnt == 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
    end
  end

  task automatic clr_cap();
    wr_cnt = 0; wr_order_err = 0; res = '0; first_wr = 0; last_wr = 0;
  endtask

  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wide_t model(input vec_t a, input vec_t b, input logic sub);
    if (sub) return {(a >= b), a - b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    for (int i = 0; i < WORDS; i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  task automatic load(input vec_t a, input vec_t b);
    for (int i = 0; i < WORDS; i++) begin
      mem_a[i] = a[i*W +: W];
      mem_b[i] = b[i*W +: W];
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rden"},  wide_t'(bus.oRdEn),   '0);
    chk({tag, " rdadr"}, wide_t'(bus.oRdAddr), '0);
    chk({tag, " wren"},  wide_t'(bus.oWrEn),   '0);
    chk({tag, " wradr"}, wide_t'(bus.oWrAddr), '0);
    chk({tag, " wrdat"}, wide_t'(bus.oWrData), '0);
    chk({tag, " busy"},  wide_t'(bus.oBusy),   '0);
    chk({tag, " done"},  wide_t'(bus.oDone),   '0);
    chk({tag, " carry"}, wide_t'(bus.oCarry),  '0);
  endtask

  task automatic start_op(input logic sub, input string tag, input logic hold);
    @(negedge iClk);
    bus.iStart = 1'b1;
    bus.iSub   = sub;
    @(posedge iClk); #1;
    chk({tag, " st busy"}, wide_t'(bus.oBusy),   wide_t'(1));
    chk({tag, " st rden"}, wide_t'(bus.oRdEn),   wide_t'(1));
    chk({tag, " st adr"},  wide_t'(bus.oRdAddr), '0);
    if (!hold) bus.iStart = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.oDone && lat < 4*WORDS) begin
      @(posedge iClk); #1;
      lat++;
    end
  endtask

  task automatic chk_result(input string tag, input wide_t exp);
    chk({tag, " data"},  wide_t'(res),          wide_t'(exp[N-1:0]));
    chk({tag, " nwr"},   wide_t'(wr_cnt),       wide_t'(WORDS));
    chk({tag, " order"}, wide_t'(wr_order_err), '0);
    chk({tag, " span"},  wide_t'(last_wr - first_wr), wide_t'(WORDS-1));
  endtask

  task automatic run_check(input vec_t a, input vec_t b, input logic sub,
                           input string tag, input logic hold);
    wide_t exp;
    int    lat;
    exp = model(a, b, sub);
    load(a, b);
    clr_cap();
    start_op(sub, tag, hold);
    wait_done(lat);
    chk({tag, " lat"},   wide_t'(lat),        wide_t'(WORDS+1));
    chk({tag, " carry"}, wide_t'(bus.oCarry), wide_t'(exp[N]));
    chk({tag, " dbusy"}, wide_t'(bus.oBusy),  wide_t'(1));
    @(posedge iClk); #1;
    chk({tag, " idle"},  wide_t'({bus.oBusy, bus.oDone, bus.oWrEn}), '0);
    chk_result(tag, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  a, b;
    wide_t exp;
    logic  c0;
    int    lat;

    bus.iStart = 1'b0; bus.iSub = 1'b0; bus.iAbort = 1'b0;
    iRst_n = 1'b0;
    clr_cap();
    #22;
    chk_zero("reset");
    #5 iRst_n = 1'b1;

    // All-ones + 1 ripples a carry through every word
    a = '1; b = vec_t'(1);
    run_check(a, b, 1'b0, "ones+1", 1'b0);
    // 0 - 1 borrows through every word
    a = '0; b = vec_t'(1);
    run_check(a, b, 1'b1, "0-1", 1'b0);
    // Carry from word0 into word1 only
    a = vec_t'(32'hFFFF_FFFF); b = vec_t'(1);
    run_check(a, b, 1'b0, "w0carry", 1'b0);
    // A - A: zero result, no borrow
    a = rnd();
    run_check(a, a, 1'b1, "a-a", 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_check(rnd(), rnd(), 1'($urandom_range(1)), $sformatf("rand%0d", i), 1'b0);
    end

    // Abort on the 10th RUN cycle, then an immediate 0+0
    load(rnd(), rnd());
    clr_cap();
    c0 = bus.oCarry;
    start_op(1'b0, "abrt", 1'b0);
    repeat (9) begin @(posedge iClk); #1; end
    bus.iAbort = 1'b1;
    @(posedge iClk); #1;
    bus.iAbort = 1'b0;
    chk("abrt wren",  wide_t'(bus.oWrEn),  '0);
    chk("abrt busy",  wide_t'(bus.oBusy),  '0);
    chk("abrt rden",  wide_t'(bus.oRdEn),  '0);
    chk("abrt done",  wide_t'(bus.oDone),  '0);
    chk("abrt carry", wide_t'(bus.oCarry), wide_t'(c0));
    chk("abrt nwr",   wide_t'(wr_cnt),     wide_t'(8));
    run_check('0, '0, 1'b0, "0+0", 1'b0);

    // Abort in DRAIN beats completion; operands chosen so completion would flip oCarry
    c0 = bus.oCarry;
    if (c0) begin a = '0; b = '0; end else begin a = '1; b = vec_t'(1); end
    load(a, b);
    clr_cap();
    start_op(1'b0, "drain", 1'b0);
    repeat (WORDS) begin @(posedge iClk); #1; end
    bus.iAbort = 1'b1;
    @(posedge iClk); #1;
    bus.iAbort = 1'b0;
    chk("drain done",  wide_t'(bus.oDone),  '0);
    chk("drain busy",  wide_t'(bus.oBusy),  '0);
    chk("drain carry", wide_t'(bus.oCarry), wide_t'(c0));
    @(posedge iClk); #1;
    chk("drain nwr",   wide_t'(wr_cnt),     wide_t'(WORDS-1));
    chk("drain done2", wide_t'(bus.oDone),  '0);

    // Abort in IDLE does not block a start; abort in RUN then cancels it
    @(negedge iClk);
    bus.iAbort = 1'b1; bus.iStart = 1'b1; bus.iSub = 1'b0;
    @(posedge iClk); #1;
    bus.iStart = 1'b0;
    chk("idleab busy", wide_t'(bus.oBusy), wide_t'(1));
    @(posedge iClk); #1;
    bus.iAbort = 1'b0;
    chk("runab busy",  wide_t'(bus.oBusy), '0);

    // Asynchronous reset mid-RUN
    load(rnd(), rnd());
    clr_cap();
    start_op(1'b0, "rst", 1'b0);
    repeat (12) begin @(posedge iClk); #1; end
    #2 iRst_n = 1'b0;
    #1;
    chk_zero("midrst");
    clr_cap();
    @(posedge iClk); #3 iRst_n = 1'b1;
    repeat (4) begin @(posedge iClk); #1; end
    chk("postrst nwr", wide_t'(wr_cnt), '0);
    run_check(rnd(), rnd(), 1'b0, "afterrst", 1'b0);

    // iStart held high: one op per IDLE visit, next accepted right after DONE
    a = rnd(); b = rnd();
    run_check(a, b, 1'b0, "hold1", 1'b1);
    @(posedge iClk); #1;
    bus.iStart = 1'b0;
    chk("hold2 busy", wide_t'(bus.oBusy),   wide_t'(1));
    chk("hold2 adr",  wide_t'(bus.oRdAddr), '0);
    clr_cap();
    wait_done(lat);
    exp = model(a, b, 1'b0);
    chk("hold2 lat",   wide_t'(lat),        wide_t'(WORDS+1));
    chk("hold2 carry", wide_t'(bus.oCarry), wide_t'(exp[N]));
    @(posedge iClk); #1;
    chk_result("hold2", exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter W, default 32: datapath word width in bits.
REQ-002 SHALL have parameter WORDS, default 32: words per operand (1024-bit default); legal range 2..256.
REQ-003 SHALL have parameter AW, default 5: address width, equal to clog2(WORDS).
REQ-004 SHALL have port iClk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port iRst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port iStart, input, 1: operation request, sampled only in IDLE.
REQ-007 SHALL have port iSub, input, 1: 0 selects A+B, 1 selects A-B; sampled with iStart.
REQ-008 SHALL have port iAbort, input, 1: synchronous cancel of a running operation.
REQ-009 SHALL have port oRdEn, output, 1: operand read strobe.
REQ-010 SHALL have port oRdAddr, output, AW: operand word index, LSW = 0.
REQ-011 SHALL have ports iA and iB, input, W each: operand words, valid exactly one cycle after the matching oRdEn/oRdAddr.
REQ-012 SHALL have ports oWrEn (output, 1), oWrAddr (output, AW) and oWrData (output, W): result write port.
REQ-013 SHALL have port oBusy, output, 1: operation in progress.
REQ-014 SHALL have port oDone, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port oCarry, output, 1: final carry out (subtract: 1 = no borrow); held until the next start.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-017 SHALL register all outputs.
REQ-018 SHALL, on edge E0 with state IDLE and iStart=1, latch iSub, load carry with iSub, go to RUN, and drive oBusy=1, oRdEn=1, oRdAddr=0.
REQ-019 SHALL, in RUN, advance oRdAddr by 1 per edge; after the edge issuing WORDS-1, drop oRdEn and go to DRAIN.
REQ-020 SHALL compute sum = iA + (iSub ? ~iB : iB) + carry each cycle from E1 onward, in W+1 bits.
REQ-021 SHALL, at E(i+2) for i = 0..WORDS-1, register oWrEn=1, oWrAddr=i and oWrData=sum[W-1:0], and update carry to sum[W].
REQ-022 SHALL, in the cycle holding the final write (i = WORDS-1), assert oDone=1 and update oCarry, then go DONE -> IDLE on the next edge with oBusy=0.
REQ-023 SHALL therefore give a start-to-oDone latency of WORDS+1 cycles (33 at default), with oWrEn high for exactly WORDS consecutive cycles.
REQ-024 SHALL ignore iStart outside IDLE, including in the oDone cycle.
REQ-025 SHALL, on iAbort=1 in RUN or DRAIN, clear oRdEn, oWrEn and oBusy at the next edge, return to IDLE, leave oDone low and oCarry unchanged, and clear carry.
REQ-026 SHALL give iAbort priority over completion when both occur in the same cycle.
REQ-027 SHALL treat iAbort in IDLE or DONE as a no-op.
REQ-028 SHALL discard carry out of word WORDS-1 except into oCarry; no carry propagates into the next operation.

Reset
REQ-029 SHALL, while iRst_n=0, immediately force state IDLE, carry=0, oCarry=0, oRdEn=0, oRdAddr=0, oWrEn=0, oWrAddr=0, oWrData=0, oBusy=0 and oDone=0.
REQ-030 SHALL abandon an in-flight operation on reset, with no further writes after reset deasserts.
REQ-031 SHALL accept iStart on the first edge after reset release.

Structure
REQ-032 SHALL place the FSM state encoding and the default W and WORDS constants in shared package mp_add_pkg.
REQ-033 SHALL contain exactly one sub-module, word_adc: combinational W-bit add with carry-in and optional B inversion, producing W-bit sum and carry-out.
REQ-034 SHALL keep the word counter AW bits wide; the write index SHALL be the read index delayed by one cycle, not a separate counter.

Verification
REQ-035 SHALL pass: A = all-ones (1024 bits), B = 1, iSub=0 -> 32 writes of 0x00000000 at addresses 0..31, oCarry=1, oDone exactly 33 cycles after start.
REQ-036 SHALL pass: A = 0, B = 1, iSub=1 -> all words 0xFFFFFFFF, oCarry=0 (borrow).
REQ-037 SHALL pass: A word0 = 0xFFFFFFFF, B word0 = 0x00000001, all other words 0 -> word0 = 0, word1 = 0x00000001, remaining words 0, oCarry=0.
REQ-038 SHALL pass: iAbort on the 10th cycle of RUN -> oWrEn low from the next edge, no oDone; an immediate new start of 0+0 yields all-zero result with oCarry=0.
REQ-039 SHALL pass: iRst_n pulsed low mid-RUN -> all outputs zero asynchronously; a subsequent normal add completes correctly.
REQ-040 SHALL pass: iStart held high through an entire operation -> exactly one operation per IDLE visit; the second start is accepted the cycle after DONE.
